router_fsm: RTL
===============

ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 The block SHALL have no parameters; the port count is fixed at 3 and the address is 2 bits.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 pkt_valid  input  1  source indicates header/payload bytes are valid.
REQ-005 data_in  input  2  destination address field of the header byte (0,1,2 legal; 3 illegal).
REQ-006 fifo_full  input  1  full flag of the currently addressed output FIFO.
REQ-007 fifo_empty_0/1/2  input  1 each  empty flags of output FIFOs 0..2.
REQ-008 soft_reset_0/1/2  input  1 each  per-port timeout reset from the synchronizer.
REQ-009 parity_done  input  1  register block has stored the parity byte.
REQ-010 low_pkt_valid  input  1  pkt_valid fell while the FIFO was full.
REQ-011 detect_add, lfd_state, ld_state, laf_state, full_state  output  1 each  state decodes.
REQ-012 write_enb_reg  output  1  enables the FIFO write path.
REQ-013 rst_int_reg  output  1  clears internal parity registers.
REQ-014 busy  output  1  source must hold the current byte.

Function
REQ-015 The state machine SHALL have 8 states: DA (decode address), LFD (load first data), LD (load data), FFS (FIFO full), LAF (load after full), LP (load parity), CPE (check parity error), WTE (wait till empty).
REQ-016 A 2-bit addr register SHALL capture data_in on every clock in which state==DA and pkt_valid==1; it is held in all other states.
REQ-017 DA: pkt_valid=1, data_in in {0,1,2} and fifo_empty_<data_in>=1 -> LFD; pkt_valid=1, data_in in {0,1,2} and fifo_empty_<data_in>=0 -> WTE; otherwise stay DA.
REQ-018 data_in=3 with pkt_valid=1 SHALL leave the state in DA (header ignored, no write enable).
REQ-019 LFD -> LD unconditionally after exactly one cycle.
REQ-020 LD: fifo_full=1 -> FFS (priority); else pkt_valid=0 -> LP; else stay LD.
REQ-021 FFS: fifo_full=0 -> LAF; else stay FFS.
REQ-022 LAF: parity_done=1 -> DA; else low_pkt_valid=1 -> LP; else -> LD.
REQ-023 LP -> CPE unconditionally after one cycle.
REQ-024 CPE: fifo_full=1 -> FFS; else -> DA.
REQ-025 WTE: fifo_empty_<addr>=1 -> LFD; else stay WTE.
REQ-026 soft_reset_<addr>=1 in any state other than DA SHALL force next state DA, overriding REQ-017..025; soft resets of other ports SHALL be ignored.
REQ-027 Outputs SHALL be Moore decodes of the current state (zero-cycle latency from the state register): detect_add=DA, lfd_state=LFD, ld_state=LD, full_state=FFS, laf_state=LAF, rst_int_reg=CPE.
REQ-028 write_enb_reg SHALL be 1 in LD, LP and LAF only.
REQ-029 busy SHALL be 1 in LFD, FFS, LAF, LP, CPE and WTE; 0 in DA and LD.
REQ-030 Exactly one of the six state-decode outputs SHALL be high in DA, LFD, LD, FFS, LAF and CPE; LP and WTE SHALL have all six low.

Reset
REQ-031 resetn=0 at a clock edge SHALL force state=DA and addr=0 regardless of any other input, including mid-packet.
REQ-032 Output values during and after reset: detect_add=1; lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy=0.
REQ-033 Reset SHALL take priority over soft_reset_<addr>.

Verification
REQ-034 Header data_in=1, fifo_empty_1=1, 3 payload bytes, then pkt_valid=0 -> DA,LFD,LD,LD,LD,LP,CPE,DA; write_enb_reg=1 for the 3 LD cycles and the LP cycle.
REQ-035 Header data_in=2, fifo_empty_2=0 for 5 cycles -> WTE with busy=1 for 5 cycles, then LFD the cycle after fifo_empty_2 rises.
REQ-036 fifo_full=1 during LD -> FFS, write_enb_reg=0, busy=1; fifo_full drops -> LAF; low_pkt_valid=1 -> LP -> CPE -> DA.
REQ-037 Header data_in=3 with pkt_valid=1 -> state stays DA, detect_add=1, write_enb_reg=0.
REQ-038 soft_reset_0=1 in WTE (addr=0) -> DA next cycle; soft_reset_1=1 in the same situation -> stays WTE.
REQ-039 resetn=0 in LD -> DA next edge with the outputs of REQ-032; the next header is decoded normally.

Source files
------------

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, sequences payload/parity
// loading into the addressed output FIFO, and stalls the source while it cannot accept bytes.
module router_fsm (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        DA  = 3'd0,
        LFD = 3'd1,
        LD  = 3'd2,
        FFS = 3'd3,
        LAF = 3'd4,
        LP  = 3'd5,
        CPE = 3'd6,
        WTE = 3'd7
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic       hdr_empty;
    logic       addr_empty;
    logic       addr_soft;

    // hdr_empty looks at the incoming header; addr_empty/addr_soft at the latched port.
    always_comb begin
        hdr_empty  = 1'b0;
        addr_empty = 1'b0;
        addr_soft  = 1'b0;
        case (data_in)
            2'd0:    hdr_empty = fifo_empty_0;
            2'd1:    hdr_empty = fifo_empty_1;
            2'd2:    hdr_empty = fifo_empty_2;
            default: hdr_empty = 1'b0;
        endcase
        case (addr_q)
            2'd0:    begin addr_empty = fifo_empty_0; addr_soft = soft_reset_0; end
            2'd1:    begin addr_empty = fifo_empty_1; addr_soft = soft_reset_1; end
            2'd2:    begin addr_empty = fifo_empty_2; addr_soft = soft_reset_2; end
            default: begin addr_empty = 1'b0;         addr_soft = 1'b0;         end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= DA;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (state_q == DA && pkt_valid)
            addr_d = data_in;
        if (state_q != DA && addr_soft) begin
            state_d = DA;
        end else begin
            case (state_q)
                DA: begin
                    if (pkt_valid && data_in != 2'd3)
                        state_d = hdr_empty ? LFD : WTE;
                end
                LFD: state_d = LD;
                LD: begin
                    if (fifo_full)       state_d = FFS;
                    else if (!pkt_valid) state_d = LP;
                end
                FFS: begin
                    if (!fifo_full) state_d = LAF;
                end
                LAF: begin
                    if (parity_done)        state_d = DA;
                    else if (low_pkt_valid) state_d = LP;
                    else                    state_d = LD;
                end
                LP:  state_d = CPE;
                CPE: state_d = fifo_full ? FFS : DA;
                WTE: begin
                    if (addr_empty) state_d = LFD;
                end
                default: state_d = DA;
            endcase
        end
    end

    // Source handshake: while busy is high the source must hold data_in/pkt_valid;
    // a byte is consumed on each rising edge where busy is low.
    always_comb begin
        detect_add    = (state_q == DA);
        lfd_state     = (state_q == LFD);
        ld_state      = (state_q == LD);
        laf_state     = (state_q == LAF);
        full_state    = (state_q == FFS);
        rst_int_reg   = (state_q == CPE);
        write_enb_reg = (state_q == LD) || (state_q == LP) || (state_q == LAF);
        busy          = (state_q != DA) && (state_q != LD);
        state_dbg     = state_q;
    end

endmodule
